// File: rtl/vram_seq.sv
// Purpose : VRAM write-port sequencer; merges host word writes with a fill/scroll engine.
// Latency : host write sampled at edge t drives WR* after edge t; engine writes start the edge after CMD_START.
// Backpress: a host write always owns the write port; the engine stalls (state, n and read word held) and retries.
//
// Ports:
//   CLK, RST                         clock, synchronous active-high reset
//   HOST_WRADDR/BYTEEN/WREN/WRDATA   host single-word write, one per cycle
//   CMD_START/CMD_OP/CMD_DATA        engine command: 00 fill, 01 scroll-up, 1x no-op
//   BUSY, DONE                       engine active, one-cycle completion pulse
//   WRADDR/BYTEEN/WREN/WRDATA        VRAM write port (registered)
//   RDADDR/RDEN/RDDATA               VRAM read port (scroll only)
// Build option: define VRAM_SEQ_SCROLL_EN to implement the scroll-up op; otherwise op 01 is a no-op
// and the read port is held at zero.

module vram_seq #(
  parameter int COLS = 80,
  parameter int ROWS = 50
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [15:0] HOST_WRADDR,
  input  logic [3:0]  HOST_BYTEEN,
  input  logic        HOST_WREN,
  input  logic [31:0] HOST_WRDATA,
  input  logic        CMD_START,
  input  logic [1:0]  CMD_OP,
  input  logic [31:0] CMD_DATA,
  output logic        BUSY,
  output logic        DONE,
  output logic [15:0] WRADDR,
  output logic [3:0]  BYTEEN,
  output logic        WREN,
  output logic [31:0] WRDATA,
  output logic [15:0] RDADDR,
  output logic        RDEN,
  input  logic [31:0] RDDATA
);

  localparam logic [15:0] LAST_WORD = 16'(ROWS * COLS - 1);
`ifdef VRAM_SEQ_SCROLL_EN
  // Last word of the region that is copied up from the row below.
  localparam logic [15:0] SCROLL_END = 16'((ROWS - 1) * COLS - 1);
  localparam logic [15:0] ROW_WORDS  = 16'(COLS);
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_SC_RD,
    S_SC_WAIT,
    S_SC_WR,
    S_LAST,
    S_FIN
  } state_t;

  state_t      state, state_nxt;
  logic [15:0] n, n_nxt;
  logic [31:0] fill_dat, fill_dat_nxt;
  logic        busy_nxt, done_nxt;
  logic [15:0] wraddr_nxt, rdaddr_nxt;
  logic [3:0]  byteen_nxt;
  logic        wren_nxt, rden_nxt;
  logic [31:0] wrdata_nxt;

`ifdef VRAM_SEQ_SCROLL_EN
  // Read word kept across host stalls in SC_WR; RDDATA is only guaranteed on the first SC_WR cycle.
  logic [31:0] rd_hold, rd_hold_nxt;
  logic        rd_held, rd_held_nxt;
  logic [31:0] rd_word;
`else
  logic unused_rddata;
  assign unused_rddata = ^RDDATA;
`endif

  function automatic logic [15:0] word_addr(input logic [15:0] w);
    return {w[13:0], 2'b00};
  endfunction

  always_comb begin
    state_nxt    = state;
    n_nxt        = n;
    fill_dat_nxt = fill_dat;
    busy_nxt     = BUSY;
    done_nxt     = 1'b0;
    wraddr_nxt   = '0;
    byteen_nxt   = '0;
    wren_nxt     = 1'b0;
    wrdata_nxt   = '0;
    rdaddr_nxt   = '0;
    rden_nxt     = 1'b0;
`ifdef VRAM_SEQ_SCROLL_EN
    rd_hold_nxt  = rd_hold;
    rd_held_nxt  = rd_held;
    rd_word      = rd_held ? rd_hold : RDDATA;
`endif

    // Host write always takes the port; engine write states below check HOST_WREN and hold.
    if (HOST_WREN) begin
      wraddr_nxt = HOST_WRADDR;
      byteen_nxt = HOST_BYTEEN;
      wren_nxt   = 1'b1;
      wrdata_nxt = HOST_WRDATA;
    end

    case (state)
      S_IDLE: begin
        if (CMD_START) begin
          fill_dat_nxt = CMD_DATA;
          n_nxt        = '0;
          busy_nxt     = 1'b1;
          case (CMD_OP)
            2'b00:   state_nxt = S_FILL;
`ifdef VRAM_SEQ_SCROLL_EN
            2'b01:   state_nxt = S_SC_RD;
`else
            2'b01:   state_nxt = S_FIN;
`endif
            default: state_nxt = S_FIN;
          endcase
        end
      end

      S_FILL: begin
        if (!HOST_WREN) begin
          wraddr_nxt = word_addr(n);
          byteen_nxt = 4'hf;
          wren_nxt   = 1'b1;
          wrdata_nxt = fill_dat;
          if (n == LAST_WORD) state_nxt = S_FIN;
          else                n_nxt     = n + 16'd1;
        end
      end

`ifdef VRAM_SEQ_SCROLL_EN
      S_SC_RD: begin
        rden_nxt    = 1'b1;
        rdaddr_nxt  = word_addr(n + ROW_WORDS);
        rd_held_nxt = 1'b0;
        state_nxt   = S_SC_WAIT;
      end

      S_SC_WAIT: state_nxt = S_SC_WR;

      S_SC_WR: begin
        if (HOST_WREN) begin
          rd_hold_nxt = rd_word;
          rd_held_nxt = 1'b1;
        end else begin
          wraddr_nxt = word_addr(n);
          byteen_nxt = 4'hf;
          wren_nxt   = 1'b1;
          wrdata_nxt = rd_word;
          n_nxt      = n + 16'd1;
          state_nxt  = (n == SCROLL_END) ? S_LAST : S_SC_RD;
        end
      end

      S_LAST: begin
        if (!HOST_WREN) begin
          wraddr_nxt = word_addr(n);
          byteen_nxt = 4'hf;
          wren_nxt   = 1'b1;
          wrdata_nxt = fill_dat;
          if (n == LAST_WORD) state_nxt = S_FIN;
          else                n_nxt     = n + 16'd1;
        end
      end
`endif

      S_FIN: begin
        done_nxt  = 1'b1;
        busy_nxt  = 1'b0;
        state_nxt = S_IDLE;
      end

      default: begin
        busy_nxt  = 1'b0;
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= S_IDLE;
      n        <= '0;
      fill_dat <= '0;
      BUSY     <= 1'b0;
      DONE     <= 1'b0;
      WRADDR   <= '0;
      BYTEEN   <= '0;
      WREN     <= 1'b0;
      WRDATA   <= '0;
      RDADDR   <= '0;
      RDEN     <= 1'b0;
`ifdef VRAM_SEQ_SCROLL_EN
      rd_hold  <= '0;
      rd_held  <= 1'b0;
`endif
    end else begin
      state    <= state_nxt;
      n        <= n_nxt;
      fill_dat <= fill_dat_nxt;
      BUSY     <= busy_nxt;
      DONE     <= done_nxt;
      WRADDR   <= wraddr_nxt;
      BYTEEN   <= byteen_nxt;
      WREN     <= wren_nxt;
      WRDATA   <= wrdata_nxt;
      RDADDR   <= rdaddr_nxt;
      RDEN     <= rden_nxt;
`ifdef VRAM_SEQ_SCROLL_EN
      rd_hold  <= rd_hold_nxt;
      rd_held  <= rd_held_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_vram_seq.sv
module tb_vram_seq;
  localparam int COLS = 4;
  localparam int ROWS = 3;
  localparam int NW   = COLS * ROWS;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [15:0] HOST_WRADDR = '0;
  logic [3:0]  HOST_BYTEEN = '0;
  logic        HOST_WREN   = 1'b0;
  logic [31:0] HOST_WRDATA = '0;
  logic        CMD_START   = 1'b0;
  logic [1:0]  CMD_OP      = '0;
  logic [31:0] CMD_DATA    = '0;
  logic        BUSY, DONE, WREN, RDEN;
  logic [15:0] WRADDR, RDADDR;
  logic [3:0]  BYTEEN;
  logic [31:0] WRDATA;
  logic [31:0] RDDATA = '0;

  vram_seq #(.COLS(COLS), .ROWS(ROWS)) dut (
    .CLK(CLK), .RST(RST),
    .HOST_WRADDR(HOST_WRADDR), .HOST_BYTEEN(HOST_BYTEEN),
    .HOST_WREN(HOST_WREN), .HOST_WRDATA(HOST_WRDATA),
    .CMD_START(CMD_START), .CMD_OP(CMD_OP), .CMD_DATA(CMD_DATA),
    .BUSY(BUSY), .DONE(DONE),
    .WRADDR(WRADDR), .BYTEEN(BYTEEN), .WREN(WREN), .WRDATA(WRDATA),
    .RDADDR(RDADDR), .RDEN(RDEN), .RDDATA(RDDATA)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [15:0] a;
    logic [3:0]  be;
    logic [31:0] d;
  } wr_t;

  // VRAM model: synchronous read, byte-enabled write, plus a log of every write issued.
  logic [31:0] mem [0:63];
  wr_t         wr_log[$];
  int          rden_cnt = 0;
  int          checks = 0;
  int          errors = 0;

  always @(posedge CLK) begin
    if (RDEN) begin
      RDDATA <= mem[RDADDR[7:2]];
      rden_cnt++;
    end
    if (WREN) begin
      for (int b = 0; b < 4; b++)
        if (BYTEEN[b]) mem[WRADDR[7:2]][8*b +: 8] = WRDATA[8*b +: 8];
      wr_log.push_back('{a: WRADDR, be: BYTEEN, d: WRDATA});
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(negedge CLK);
  endtask

  task automatic start(input logic [1:0] op, input logic [31:0] d);
    CMD_START = 1'b1;
    CMD_OP    = op;
    CMD_DATA  = d;
    tick();
    CMD_START = 1'b0;
  endtask

  // Ticks until DONE is seen; returns the number of edges after the start edge, or -1 on timeout.
  task automatic run_done(output int dk);
    dk = -1;
    for (int k = 1; k <= 200; k++) begin
      tick();
      if (DONE === 1'b1) begin
        dk = k;
        break;
      end
    end
  endtask

  // Engine writes land below 0x40; every word of the screen exactly once, in order.
  task automatic check_fill_writes(input string tag, input logic [31:0] d);
    int e;
    e = 0;
    foreach (wr_log[i]) begin
      if (wr_log[i].a < 16'h40) begin
        chk({tag, "_addr"}, 32'(wr_log[i].a), 32'(e * 4));
        chk({tag, "_data"}, wr_log[i].d, d);
        chk({tag, "_be"}, 32'(wr_log[i].be), 32'hf);
        e++;
      end
    end
    chk({tag, "_count"}, 32'(e), 32'(NW));
    for (int i = 0; i < NW; i++) chk({tag, "_mem"}, mem[i], d);
  endtask

  initial begin
    int   dk, kw, free, hi, busy_seen, done_seen;
    logic hb [0:63];
    wr_t  host_exp[$];
    wr_t  h;
    logic [31:0] fd, fd2, fd3, fd4, exp_w;

    for (int i = 0; i < 64; i++) mem[i] = 32'hDEAD_0000 | 32'(i);

    // Reset
    repeat (10) tick();
    chk("rst_wraddr", 32'(WRADDR), 0);
    chk("rst_byteen", 32'(BYTEEN), 0);
    chk("rst_wren",   32'(WREN),   0);
    chk("rst_wrdata", WRDATA,      0);
    chk("rst_rdaddr", 32'(RDADDR), 0);
    chk("rst_rden",   32'(RDEN),   0);
    chk("rst_busy",   32'(BUSY),   0);
    chk("rst_done",   32'(DONE),   0);
    RST = 1'b0;
    tick(); tick();
    chk("idle_wren", 32'(WREN), 0);
    chk("idle_busy", 32'(BUSY), 0);

    // Host passthrough
    HOST_WREN = 1'b1; HOST_WRADDR = 16'h0010; HOST_BYTEEN = 4'h3; HOST_WRDATA = 32'h0000_0141;
    tick();
    HOST_WREN = 1'b0;
    chk("pass_wren",   32'(WREN),   1);
    chk("pass_wraddr", 32'(WRADDR), 32'h10);
    chk("pass_byteen", 32'(BYTEEN), 32'h3);
    chk("pass_wrdata", WRDATA,      32'h0000_0141);
    tick();
    chk("pass_wren_off", 32'(WREN), 0);

    // Unstalled fill; a second command mid-run must be ignored
    wr_log.delete();
    fd = 32'h0007_0020;
    start(2'b00, fd);
    chk("fill_busy", 32'(BUSY), 1);
    dk = -1;
    for (int k = 1; k <= 200; k++) begin
      if (k == 5) begin CMD_START = 1'b1; CMD_OP = 2'b10; end
      tick();
      CMD_START = 1'b0;
      if (DONE === 1'b1) begin dk = k; break; end
    end
    chk("fill_done_cycle", 32'(dk), 13);
    chk("fill_busy_at_done", 32'(BUSY), 0);
    check_fill_writes("fill", fd);
    tick();
    chk("fill_done_pulse", 32'(DONE), 0);

    // Fill with random host contention; host writes target words 16+
    wr_log.delete();
    host_exp.delete();
    fd2 = $urandom;
    hb[0] = 1'b1;
    for (int k = 1; k < 64; k++) hb[k] = (k <= 30) ? 1'($urandom_range(0, 1)) : 1'b0;
    free = 0; kw = 0;
    for (int k = 1; k < 64; k++) begin
      if (!hb[k]) begin
        free++;
        if (free == NW) begin kw = k; break; end
      end
    end
    hi = 0;
    dk = -1;
    for (int k = 0; k <= 200; k++) begin
      HOST_WREN = (k <= kw) ? hb[k] : 1'b0;
      if (HOST_WREN) begin
        h.a = 16'h40 + 16'(4 * hi);
        h.be = 4'($urandom_range(1, 15));
        h.d = $urandom;
        HOST_WRADDR = h.a; HOST_BYTEEN = h.be; HOST_WRDATA = h.d;
        host_exp.push_back(h);
        hi++;
      end
      if (k == 0) start(2'b00, fd2);
      else tick();
      if (k > 0 && DONE === 1'b1) begin dk = k; break; end
    end
    HOST_WREN = 1'b0;
    chk("cont_done_cycle", 32'(dk), 32'(kw + 1));
    begin
      int j;
      j = 0;
      foreach (wr_log[i]) begin
        if (wr_log[i].a >= 16'h40) begin
          if (j < host_exp.size()) begin
            chk("cont_host_addr", 32'(wr_log[i].a), 32'(host_exp[j].a));
            chk("cont_host_be",   32'(wr_log[i].be), 32'(host_exp[j].be));
            chk("cont_host_data", wr_log[i].d, host_exp[j].d);
          end
          j++;
        end
      end
      chk("cont_host_count", 32'(j), 32'(host_exp.size()));
    end
    check_fill_writes("cont", fd2);

    // Scroll-up with VRAM word n preloaded to n
    for (int i = 0; i < NW; i++) mem[i] = 32'(i);
    tick();
    wr_log.delete();
    rden_cnt = 0;
    start(2'b01, 32'hFF);
    run_done(dk);
`ifdef VRAM_SEQ_SCROLL_EN
    chk("scroll_done_cycle", 32'(dk), 32'(3 * (ROWS - 1) * COLS + COLS + 1));
    chk("scroll_reads", 32'(rden_cnt), 32'((ROWS - 1) * COLS));
    for (int i = 0; i < NW; i++) begin
      exp_w = (i < (ROWS - 1) * COLS) ? 32'(i + COLS) : 32'hFF;
      chk("scroll_mem", mem[i], exp_w);
    end
`else
    chk("scroll_noop_done", 32'(dk), 1);
    chk("scroll_noop_reads", 32'(rden_cnt), 0);
    chk("scroll_noop_writes", 32'(wr_log.size()), 0);
    for (int i = 0; i < NW; i++) chk("scroll_noop_mem", mem[i], 32'(i));
`endif
    tick();

    // Reserved op: no writes, DONE one cycle later
    wr_log.delete();
    start(2'b11, $urandom);
    run_done(dk);
    chk("rsvd_done_cycle", 32'(dk), 1);
    chk("rsvd_writes", 32'(wr_log.size()), 0);
    tick();

    // Abort mid-fill: reset as word 5 is about to be written
    fd3 = $urandom;
    start(2'b00, fd3);
    repeat (5) tick();
    chk("abort_pre_addr", 32'(WRADDR), 32'h10);
    RST = 1'b1;
    tick();
    chk("abort_wren",   32'(WREN),   0);
    chk("abort_busy",   32'(BUSY),   0);
    chk("abort_done",   32'(DONE),   0);
    chk("abort_wraddr", 32'(WRADDR), 0);
    RST = 1'b0;
    busy_seen = 0; done_seen = 0;
    repeat (20) begin
      tick();
      if (DONE !== 1'b0) done_seen++;
      if (BUSY !== 1'b0 || WREN !== 1'b0) busy_seen++;
    end
    chk("abort_no_done", 32'(done_seen), 0);
    chk("abort_no_resume", 32'(busy_seen), 0);
    wr_log.delete();
    fd4 = ~fd3;
    start(2'b00, fd4);
    run_done(dk);
    chk("refill_done_cycle", 32'(dk), 13);
    check_fill_writes("refill", fd4);

    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
